// File: rtl/phase_gather.sv
// phase_gather: gathers four channel-tagged phase samples into one frame and strobes it out, spaced by MIN_GAP
module phase_gather #(
  parameter int WIDTH = 16,
  parameter int MIN_GAP = 190,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [1:0]              in_chan,
  input  logic signed [WIDTH-1:0] in_phase,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] phase1,
  output logic signed [WIDTH-1:0] phase2,
  output logic signed [WIDTH-1:0] phase3,
  output logic signed [WIDTH-1:0] phase4,
  output logic                    enable,
  output logic                    overrun,
  output logic                    dup_err,
  output logic                    timeout_err
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = $clog2(MIN_GAP + 1);
  typedef enum logic [1:0] {IDLE, COLLECT, WAIT} state_t;
  state_t state;
  logic signed [WIDTH-1:0] stage [4];
  logic signed [WIDTH-1:0] stage_n [4];
  logic [3:0] mask, hot;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  logic last, accept, fresh, done, gap_ok, issue;
  always_comb begin
    last = state == COLLECT && tcnt == TW'(TIMEOUT - 1);
    in_ready = state != WAIT && !last && !enable;
    accept = in_valid && in_ready;
    hot = 4'b0001 << in_chan;
    fresh = accept && !mask[in_chan];
    done = fresh && (mask | hot) == 4'hf;
    // gap_ok means gcnt will read zero in the cycle an issue would land
    gap_ok = enable ? MIN_GAP == 1 : gcnt <= GW'(1);
    issue = (done || state == WAIT) && gap_ok;
    for (int i = 0; i < 4; i++) stage_n[i] = fresh && in_chan == 2'(i) ? in_phase : stage[i];
  end
  always_ff @(posedge clock) begin
    stage <= stage_n;
    if (reset) begin
      state <= IDLE;
      mask <= '0;
      tcnt <= '0;
      gcnt <= '0;
      enable <= 1'b0;
      overrun <= 1'b0;
      dup_err <= 1'b0;
      timeout_err <= 1'b0;
      phase1 <= '0;
      phase2 <= '0;
      phase3 <= '0;
      phase4 <= '0;
    end else begin
      enable <= issue;
      overrun <= in_valid && !in_ready;
      dup_err <= accept && mask[in_chan];
      timeout_err <= last;
      gcnt <= enable ? GW'(MIN_GAP - 1) : gcnt - GW'(gcnt != '0);
      tcnt <= state == IDLE ? TW'(1) : tcnt + TW'(1);
      if (issue) begin
        phase1 <= stage_n[0];
        phase2 <= stage_n[1];
        phase3 <= stage_n[2];
        phase4 <= stage_n[3];
        state <= IDLE;
        mask <= '0;
      end else if (done) begin
        state <= WAIT;
        mask <= 4'hf;
      end else if (last) begin
        state <= IDLE;
        mask <= '0;
      end else if (fresh) begin
        state <= COLLECT;
        mask <= mask | hot;
      end
    end
  end
endmodule

// File: tb/tb_phase_gather.sv
// tb_phase_gather: cycle-level frame model plus directed literal checks and randomized traffic
module tb_phase_gather;
  localparam int W = 16, GAP = 190, TO = 16;
  logic clk = 0, rst = 1, in_valid = 0;
  logic [1:0] in_chan = 0;
  logic signed [W-1:0] in_phase = 0;
  logic in_ready, enable, overrun, dup_err, timeout_err;
  logic signed [W-1:0] phase1, phase2, phase3, phase4;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  phase_gather #(.WIDTH(W), .MIN_GAP(GAP), .TIMEOUT(TO)) dut (
    .clock(clk), .reset(rst), .in_valid(in_valid), .in_chan(in_chan), .in_phase(in_phase),
    .in_ready(in_ready), .phase1(phase1), .phase2(phase2), .phase3(phase3), .phase4(phase4),
    .enable(enable), .overrun(overrun), .dup_err(dup_err), .timeout_err(timeout_err)
  );
  task automatic check(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // frame model in terms of cycle numbers: first sample cycle, last enable cycle, channels held
  int cyc = 0, first = 0, last_en = -1000000;
  bit chk = 0, open = 0, full = 0, exp_en = 0, exp_ov = 0, exp_dup = 0, exp_to = 0;
  bit have [4];
  logic signed [W-1:0] val [4];
  logic signed [W-1:0] exp_ph [4] = '{default: 0};
  always @(negedge clk) begin : model
    bit rdy, acc, n_en, n_to;
    rdy = !full && !(open && cyc == first + TO - 1) && !exp_en;
    if (chk) begin
      check("in_ready", in_ready, rdy);
      check("enable", enable, exp_en);
      check("overrun", overrun, exp_ov);
      check("dup_err", dup_err, exp_dup);
      check("timeout_err", timeout_err, exp_to);
      check("phase1", phase1, exp_ph[0]);
      check("phase2", phase2, exp_ph[1]);
      check("phase3", phase3, exp_ph[2]);
      check("phase4", phase4, exp_ph[3]);
    end
    if (rst) begin
      open = 0; full = 0; have = '{default: 0};
      exp_en = 0; exp_ov = 0; exp_dup = 0; exp_to = 0;
      exp_ph = '{default: 0};
      last_en = -1000000;
      chk = 1;
    end else begin
      acc = in_valid && rdy;
      exp_ov = in_valid && !rdy;
      exp_dup = acc && have[in_chan];
      if (exp_en) last_en = cyc;
      n_en = 0; n_to = 0;
      if (acc && !have[in_chan]) begin
        if (!open) begin open = 1; first = cyc; end
        have[in_chan] = 1;
        val[in_chan] = in_phase;
        full = have[0] && have[1] && have[2] && have[3];
      end
      if (full && cyc + 1 >= last_en + GAP) begin
        n_en = 1; exp_ph = val; open = 0; full = 0; have = '{default: 0};
      end else if (open && !full && cyc == first + TO - 1) begin
        n_to = 1; open = 0; have = '{default: 0};
      end
      exp_en = n_en;
      exp_to = n_to;
    end
    cyc++;
  end
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(int ch, int v);
    in_valid = 1; in_chan = 2'(ch); in_phase = W'(v);
    tick();
    in_valid = 0;
  endtask
  task automatic frame(int a, int b, int c, int d);
    send(0, a); send(1, b); send(2, c); send(3, d);
  endtask
  task automatic expect_frame(string nm, int a, int b, int c, int d);
    check({nm, "_enable"}, enable, 1);
    check({nm, "_p1"}, phase1, a);
    check({nm, "_p2"}, phase2, b);
    check({nm, "_p3"}, phase3, c);
    check({nm, "_p4"}, phase4, d);
  endtask
  task automatic wait_enable(string nm, output int k);
    k = 0;
    while (!enable && k < 400) begin tick(); k++; end
    check({nm, "_enable_seen"}, enable, 1);
  endtask
  initial begin
    int k, rate;
    tick(3);
    rst = 0;
    check("rst_in_ready", in_ready, 1);
    check("rst_enable", enable, 0);
    check("rst_phase1", phase1, 0);
    frame(5535, 17504, -5985, 5759);
    expect_frame("basic", 5535, 17504, -5985, 5759);
    tick();
    check("basic_one_cycle", enable, 0);
    check("basic_hold", phase3, -5985);
    tick(200);
    send(2, 5535); send(0, -5985); send(3, 17504); send(1, 5759);
    expect_frame("ooo", -5985, 5759, 5535, 17504);
    tick(200);
    frame(1, 2, 3, 4);
    check("gap_first", enable, 1);
    tick();
    frame(16383, 16383, -16383, 0);
    check("gap_wait_ready", in_ready, 0);
    wait_enable("gap", k);
    check("gap_spacing", k + 5, 190);
    expect_frame("gap", 16383, 16383, -16383, 0);
    tick(200);
    frame(1, 1, 1, 1);
    tick();
    frame(2, 2, 2, 2);
    send(0, 77);
    check("overrun_pulse", overrun, 1);
    tick();
    check("overrun_width", overrun, 0);
    wait_enable("ovr", k);
    tick(2);
    send(0, 5); send(1, 6);
    rst = 1;
    tick(2);
    rst = 0;
    check("mid_rst_phase1", phase1, 0);
    check("mid_rst_enable", enable, 0);
    tick(20);
    check("mid_rst_no_enable", enable, 0);
    tick(200);
    send(0, 10); send(1, 20); send(1, 999);
    check("dup_pulse", dup_err, 1);
    send(2, 30);
    check("dup_width", dup_err, 0);
    send(3, 40);
    expect_frame("dup", 10, 20, 30, 40);
    tick(200);
    send(0, 1); send(1, 2); send(2, 3);
    tick(12);
    check("to_last_ready", in_ready, 0);
    tick();
    check("to_pulse", timeout_err, 1);
    check("to_no_enable", enable, 0);
    tick();
    check("to_width", timeout_err, 0);
    frame(100, 200, 300, -400);
    expect_frame("after_to", 100, 200, 300, -400);
    rate = 40;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) rate = $urandom_range(10, 95);
      rst = $urandom_range(0, 999) == 0;
      in_valid = $urandom_range(0, 99) < rate;
      in_chan = 2'($urandom_range(0, 3));
      in_phase = W'($urandom);
      tick();
    end
    in_valid = 0; rst = 0;
    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
